// File: rtl/pll_drp_if.sv
// DRP request/response bus between the PLL reconfiguration sequencer and the PLL.
`timescale 1ns/1ps
interface pll_drp_if;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic        den;
  logic        dwe;
  logic [15:0] dout;
  logic        drdy;

  modport master (output daddr, output di, output den, output dwe,
                  input  dout,  input  drdy);
  modport slave  (input  daddr, input  di, input  den, input  dwe,
                  output dout,  output drdy);
endinterface

// File: rtl/pll_drp_sequencer.sv
// Holds the PLL in reset, read-modify-writes a table of DRP registers,
// then releases reset and waits for lock, with timeouts on every wait.
`timescale 1ns/1ps
module pll_drp_sequencer #(
  parameter int unsigned              NUM_REGS     = 2,
  parameter logic [NUM_REGS*7-1:0]    ADDR_LIST    = {7'h09, 7'h08},
  parameter logic [NUM_REGS*16-1:0]   MASK_LIST    = {16'h8000, 16'h1000},
  parameter logic [NUM_REGS*16-1:0]   DATA_LIST    = {16'h0000, 16'h0041},
  parameter int unsigned              RST_CYCLES   = 4,
  parameter int unsigned              DRDY_TIMEOUT = 64,
  parameter int unsigned              LOCK_TIMEOUT = 4096
) (
  input  logic       dclk,
  input  logic       rstn,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error,
  pll_drp_if.master  drp,
  output logic       pll_rst,
  input  logic       locked
);

  localparam int unsigned AW      = 7;
  localparam int unsigned DW      = 16;
  localparam int unsigned IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned MAX_RD  = (DRDY_TIMEOUT > RST_CYCLES) ? DRDY_TIMEOUT : RST_CYCLES;
  localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > MAX_RD) ? LOCK_TIMEOUT : MAX_RD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE, RESET, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, LOCK_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              err_set, done_set, err_clr, wr_load;
  logic [AW-1:0]     addr_sel;
  logic [DW-1:0]     mask_sel, data_sel, wdata;

  // Next-state and per-transition strobes
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_set  = 1'b0;
    done_set = 1'b0;
    err_clr  = 1'b0;
    wr_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RESET;
          idx_d   = '0;
          err_clr = 1'b1;
        end
      end
      RESET: begin
        if (cnt_q == RST_LAST) state_d = RD_REQ;
      end
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: begin
        if (drp.drdy) begin
          wr_load = 1'b1;
          state_d = WR_REQ;
        end else if (cnt_q == DRDY_LAST) begin
          err_set = 1'b1;
          state_d = IDLE;
        end
      end
      WR_REQ:  state_d = WR_WAIT;
      WR_WAIT: begin
        if (drp.drdy) begin
          if (idx_q == IDX_LAST) begin
            state_d = LOCK_WAIT;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = RD_REQ;
          end
        end else if (cnt_q == DRDY_LAST) begin
          err_set = 1'b1;
          state_d = IDLE;
        end
      end
      LOCK_WAIT: begin
        if (locked) begin
          done_set = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == LOCK_LAST) begin
          err_set = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Table lookup for the entry being addressed next cycle
  always_comb begin
    addr_sel = '0;
    mask_sel = '0;
    data_sel = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        addr_sel = ADDR_LIST[i*AW +: AW];
        mask_sel = MASK_LIST[i*DW +: DW];
        data_sel = DATA_LIST[i*DW +: DW];
      end
    end
    wdata = (drp.dout & mask_sel) | (data_sel & ~mask_sel);
  end

  // State, index and wait counter; counter restarts on every state entry
  always_ff @(posedge dclk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_d != state_q || state_q == IDLE) cnt_q <= '0;
      else                                       cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Registered outputs decoded from the next state so they align with it
  always_ff @(posedge dclk or negedge rstn) begin
    if (!rstn) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      pll_rst   <= 1'b0;
      drp.den   <= 1'b0;
      drp.dwe   <= 1'b0;
      drp.daddr <= '0;
      drp.di    <= '0;
    end else begin
      busy    <= (state_d != IDLE);
      done    <= done_set;
      pll_rst <= (state_d inside {RESET, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT});
      drp.den <= (state_d == RD_REQ) || (state_d == WR_REQ);
      drp.dwe <= (state_d == WR_REQ);
      if (err_clr)      error <= 1'b0;
      else if (err_set) error <= 1'b1;
      if (state_d == RD_REQ || state_d == WR_REQ) drp.daddr <= addr_sel;
      if (wr_load) drp.di <= wdata;
    end
  end

endmodule

// File: tb/tb_pll_drp_sequencer.sv
// Directed bench for pll_drp_sequencer: behavioural DRP/PLL responder plus checks.
`timescale 1ns/1ps
module tb_pll_drp_sequencer;

  logic dclk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic locked;
  logic busy, done, error, pll_rst;

  pll_drp_if bus ();

  pll_drp_sequencer dut (
    .dclk    (dclk),
    .rstn    (rstn),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .drp     (bus),
    .pll_rst (pll_rst),
    .locked  (locked)
  );

  always #5 dclk = ~dclk;

  // Configuration written only by the main sequence
  bit          resp_en    = 1'b1;
  int          resp_delay = 2;
  bit          lock_en    = 1'b1;
  int          lock_delay = 10;
  logic [15:0] dout_val   = 16'hFFFF;
  int          inj_req    = 0;

  // Observations written only by the responder
  int          rd_cnt = 0, wr_cnt = 0, done_cnt = 0, busy_cyc = 0, rst_cyc = 0;
  int          b2b_cnt = 0, unstable_cnt = 0;
  logic [6:0]  wr_addr_log [64];
  logic [15:0] wr_data_log [64];

  int checks = 0;
  int errors = 0;

  // PLL model: answers each DEN after resp_delay cycles, locks lock_delay cycles after reset release
  initial begin : responder
    bit          pending;
    int          wait_left, lock_left, inj_ack;
    logic        prev_den;
    logic [6:0]  cur_addr;
    logic [15:0] cur_di;
    logic        cur_we;
    pending = 0; wait_left = 0; lock_left = 0; inj_ack = 0; prev_den = 1'b0;
    cur_addr = '0; cur_di = '0; cur_we = 1'b0;
    bus.drdy = 1'b0;
    bus.dout = 16'h0000;
    locked   = 1'b0;
    forever begin
      @(negedge dclk);
      bus.drdy = 1'b0;
      bus.dout = dout_val;
      if (busy)    busy_cyc++;
      if (pll_rst) rst_cyc++;
      if (done)    done_cnt++;
      if (bus.den && prev_den) b2b_cnt++;
      prev_den = bus.den;
      if (!rstn) pending = 0;
      if (pending && !bus.den &&
          (bus.daddr !== cur_addr || (cur_we && bus.di !== cur_di))) unstable_cnt++;
      if (pending) begin
        if (wait_left <= 1) begin
          bus.drdy = 1'b1;
          pending  = 0;
        end else begin
          wait_left--;
        end
      end
      if (inj_req != inj_ack) begin
        bus.drdy = 1'b1;
        inj_ack  = inj_req;
      end
      if (bus.den && rstn) begin
        cur_addr = bus.daddr;
        cur_di   = bus.di;
        cur_we   = bus.dwe;
        if (bus.dwe) begin
          wr_addr_log[6'(wr_cnt)] = bus.daddr;
          wr_data_log[6'(wr_cnt)] = bus.di;
          wr_cnt++;
        end else begin
          rd_cnt++;
        end
        if (resp_en) begin
          pending   = 1;
          wait_left = resp_delay;
        end
      end
      if (pll_rst) begin
        locked    = 1'b0;
        lock_left = lock_delay;
      end else if (lock_en && !locked) begin
        if (lock_left <= 1) locked = 1'b1;
        else                lock_left--;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Step to just after the falling edge, once the responder has updated
  task automatic sync();
    @(negedge dclk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    sync();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      sync();
      n++;
    end
    check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  initial begin : main
    int d0, r0, w0, b0, p0;

    // Reset values
    repeat (2) sync();
    check("rst_busy",    32'(busy),      32'd0);
    check("rst_done",    32'(done),      32'd0);
    check("rst_error",   32'(error),     32'd0);
    check("rst_pll_rst", 32'(pll_rst),   32'd0);
    check("rst_den",     32'(bus.den),   32'd0);
    check("rst_dwe",     32'(bus.dwe),   32'd0);
    check("rst_daddr",   32'(bus.daddr), 32'd0);
    check("rst_di",      32'(bus.di),    32'd0);
    rstn = 1'b1;
    repeat (3) sync();

    // Nominal sequence with DO=FFFF
    d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt; b0 = busy_cyc; p0 = rst_cyc;
    pulse_start();
    check("t1_busy",    32'(busy),    32'd1);
    check("t1_pll_rst", 32'(pll_rst), 32'd1);
    wait_idle(200, "t1");
    check("t1_done",     32'(done),  32'd1);
    check("t1_error",    32'(error), 32'd0);
    sync();
    check("t1_done_one", 32'(done),  32'd0);
    check("t1_ndone",    32'(done_cnt - d0), 32'd1);
    check("t1_nrd",      32'(rd_cnt - r0),   32'd2);
    check("t1_nwr",      32'(wr_cnt - w0),   32'd2);
    check("t1_wa0", 32'(wr_addr_log[6'(w0)]),     32'h08);
    check("t1_wd0", 32'(wr_data_log[6'(w0)]),     32'h1041);
    check("t1_wa1", 32'(wr_addr_log[6'(w0 + 1)]), 32'h09);
    check("t1_wd1", 32'(wr_data_log[6'(w0 + 1)]), 32'h8000);
    check("t1_busy_cyc", 32'(busy_cyc - b0), 32'd26);
    check("t1_rst_cyc",  32'(rst_cyc - p0),  32'd16);
    check("t1_pll_rst_end", 32'(pll_rst), 32'd0);

    // DRDY never arrives: read timeout, then a new start clears ERROR
    resp_en = 1'b0;
    d0 = done_cnt; b0 = busy_cyc;
    pulse_start();
    wait_idle(300, "t2");
    check("t2_error",    32'(error),   32'd1);
    check("t2_pll_rst",  32'(pll_rst), 32'd0);
    check("t2_ndone",    32'(done_cnt - d0), 32'd0);
    check("t2_busy_cyc", 32'(busy_cyc - b0), 32'd69);
    resp_en = 1'b1;
    d0 = done_cnt;
    pulse_start();
    check("t2_err_clr", 32'(error), 32'd0);
    check("t2_rebusy",  32'(busy),  32'd1);
    wait_idle(200, "t2b");
    check("t2_done_after", 32'(done_cnt - d0), 32'd1);
    check("t2_error_after", 32'(error), 32'd0);
    sync();

    // LOCKED never rises: lock timeout with PLL_RST low throughout LOCK_WAIT
    lock_en = 1'b0;
    d0 = done_cnt; b0 = busy_cyc; p0 = rst_cyc;
    pulse_start();
    wait_idle(5000, "t3");
    check("t3_error",    32'(error), 32'd1);
    check("t3_ndone",    32'(done_cnt - d0), 32'd0);
    check("t3_rst_cyc",  32'(rst_cyc - p0),  32'd16);
    check("t3_busy_cyc", 32'(busy_cyc - b0), 32'd4112);
    lock_en = 1'b1;
    sync();

    // Asynchronous reset during WR_WAIT, then a stray DRDY after release
    w0 = wr_cnt;
    pulse_start();
    begin
      int n = 0;
      while (wr_cnt == w0 && n < 100) begin
        sync();
        n++;
      end
      check("t4_reach_wr", 32'(wr_cnt - w0), 32'd1);
    end
    sync();
    check("t4_in_wr_wait", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    #1;
    check("t4_async_zero",
          32'({busy, done, error, bus.den, bus.dwe, pll_rst, bus.daddr, bus.di}), 32'd0);
    repeat (2) sync();
    rstn = 1'b1;
    sync();
    r0 = rd_cnt; w0 = wr_cnt;
    inj_req++;
    repeat (4) sync();
    check("t4_idle_busy", 32'(busy),    32'd0);
    check("t4_no_den",    32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);
    check("t4_pll_rst",   32'(pll_rst), 32'd0);

    // Start re-pulsed while busy and spurious DRDY in RESET; DO=0000
    dout_val = 16'h0000;
    d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt; b0 = busy_cyc;
    pulse_start();
    inj_req++;
    pulse_start();
    repeat (5) sync();
    pulse_start();
    wait_idle(200, "t5");
    check("t5_ndone", 32'(done_cnt - d0), 32'd1);
    check("t5_nrd",   32'(rd_cnt - r0),   32'd2);
    check("t5_nwr",   32'(wr_cnt - w0),   32'd2);
    check("t5_wd0",   32'(wr_data_log[6'(w0)]),     32'h0041);
    check("t5_wd1",   32'(wr_data_log[6'(w0 + 1)]), 32'h0000);
    check("t5_busy_cyc", 32'(busy_cyc - b0), 32'd26);
    dout_val = 16'hFFFF;
    sync();

    // DRDY on the last allowed wait cycle is accepted
    resp_delay = 64;
    d0 = done_cnt; w0 = wr_cnt; b0 = busy_cyc;
    pulse_start();
    wait_idle(600, "t6");
    check("t6_error",    32'(error), 32'd0);
    check("t6_ndone",    32'(done_cnt - d0), 32'd1);
    check("t6_wd0",      32'(wr_data_log[6'(w0)]), 32'h1041);
    check("t6_busy_cyc", 32'(busy_cyc - b0), 32'd274);

    // One cycle later is a timeout
    resp_delay = 65;
    d0 = done_cnt; b0 = busy_cyc;
    pulse_start();
    wait_idle(300, "t6b");
    check("t6b_error",    32'(error), 32'd1);
    check("t6b_ndone",    32'(done_cnt - d0), 32'd0);
    check("t6b_busy_cyc", 32'(busy_cyc - b0), 32'd69);
    repeat (10) sync();
    resp_delay = 2;

    // START held high restarts on the cycle after DONE
    start = 1'b1;
    begin
      int n = 0;
      sync();
      while (!done && n < 200) begin
        sync();
        n++;
      end
      check("t7_done_seen", 32'(done), 32'd1);
      check("t7_idle_at_done", 32'(busy), 32'd0);
    end
    sync();
    check("t7_restart_busy",    32'(busy),    32'd1);
    check("t7_restart_pll_rst", 32'(pll_rst), 32'd1);
    check("t7_err_clr",         32'(error),   32'd0);
    start = 1'b0;
    wait_idle(200, "t7");
    check("t7_done_end", 32'(done), 32'd1);

    check("den_back_to_back", 32'(b2b_cnt),      32'd0);
    check("drp_hold_stable",  32'(unstable_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
